// File: rtl/fft_pkg.sv
// Shared state type, fixed-point constants and elaboration-time helpers
// for the iterative radix-2 FFT.
package fft_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} fft_state_e;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TW_W      = 16;
  localparam int unsigned Q15_SHIFT = 15;
  localparam int unsigned Q15_HALF  = 1 << (Q15_SHIFT - 1);
  localparam int unsigned MAX_LOG2N = 10;
  localparam real         PI        = 3.14159265358979323846;

  function automatic int unsigned log2n(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                  input int unsigned bits);
    logic [MAX_LOG2N-1:0] r;
    logic [MAX_LOG2N-1:0] t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
      if (i < bits) begin
        r = {r[MAX_LOG2N-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

  // Q1.15 quantisation: round half away from zero, then saturate.
  function automatic logic [TW_W-1:0] q15(input real v);
    real x;
    int  r;
    x = v * 32768.0;
    x = (x >= 0.0) ? $floor(x + 0.5) : -$floor(-x + 0.5);
    if (x > 32767.0)       r = 32767;
    else if (x < -32768.0) r = -32768;
    else                   r = $rtoi(x);
    return r[TW_W-1:0];
  endfunction

  // Returns {re, im} of W = cos(2*pi*k/n) - j*sin(2*pi*k/n).
  function automatic logic [2*TW_W-1:0] twiddle(input int unsigned n, input int unsigned k);
    real ang;
    ang = 2.0 * PI * real'(k) / real'(n);
    return {q15($cos(ang)), q15(-$sin(ang))};
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Two-stage radix-2 butterfly: Q15 complex multiply, then add/sub.
// Define FFT_STAGE_SCALE_EN to halve every result with round-half-up.
module fft_butterfly
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mul_en,
  input  logic                     add_en,
  input  logic                     bypass,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic signed [DATA_W-1:0] ya_re,
  output logic signed [DATA_W-1:0] ya_im,
  output logic signed [DATA_W-1:0] yb_re,
  output logic signed [DATA_W-1:0] yb_im
);

  localparam int unsigned P_W = DATA_W + TW_W + 2;
  localparam logic signed [P_W-1:0] RND = P_W'(Q15_HALF);

  logic signed [P_W-1:0]    p_re, p_im;
  logic signed [DATA_W-1:0] t_re, t_im;
  logic signed [DATA_W:0]   s_re, s_im, d_re, d_im;

  function automatic logic signed [DATA_W-1:0] fin(input logic signed [DATA_W:0] v);
`ifdef FFT_STAGE_SCALE_EN
    logic signed [DATA_W+1:0] r;
    r = (DATA_W+2)'(v) + (DATA_W+2)'(1);
    return DATA_W'(r >>> 1);
`else
    return DATA_W'(v);
`endif
  endfunction

  always_comb begin
    p_re = P_W'(b_re) * P_W'(w_re) - P_W'(b_im) * P_W'(w_im) + RND;
    p_im = P_W'(b_re) * P_W'(w_im) + P_W'(b_im) * P_W'(w_re) + RND;
    s_re = (DATA_W+1)'(a_re) + (DATA_W+1)'(t_re);
    s_im = (DATA_W+1)'(a_im) + (DATA_W+1)'(t_im);
    d_re = (DATA_W+1)'(a_re) - (DATA_W+1)'(t_re);
    d_im = (DATA_W+1)'(a_im) - (DATA_W+1)'(t_im);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_re  <= '0;
      t_im  <= '0;
      ya_re <= '0;
      ya_im <= '0;
      yb_re <= '0;
      yb_im <= '0;
    end else begin
      if (mul_en) begin
        t_re <= bypass ? b_re : DATA_W'(p_re >>> Q15_SHIFT);
        t_im <= bypass ? b_im : DATA_W'(p_im >>> Q15_SHIFT);
      end
      if (add_en) begin
        ya_re <= fin(s_re);
        ya_im <= fin(s_im);
        yb_re <= fin(d_re);
        yb_im <= fin(d_im);
      end
    end
  end

endmodule

// File: rtl/fft_1024_point.sv
// Iterative in-place radix-2 DIT FFT: serial load, shared butterfly, serial
// natural-order output. Optional per-stage scaling via FFT_STAGE_SCALE_EN.
module fft_1024_point
  import fft_pkg::*;
#(
  parameter int unsigned N = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x0_re_i,
  input  logic [31:0] x0_im_i,
  input  logic        start_i,
  input  logic        dready_i,
  input  logic        dl_busy_i,
  output logic        fft_ready_o,
  output logic        fft_done_o,
  output logic        busy_o,
  output logic [31:0] x0_re_o,
  output logic [31:0] x0_im_o
);

  localparam int unsigned AW = log2n(N);
  localparam int unsigned SW = 4;
  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [AW-2:0] BF_LAST = (AW-1)'(N / 2 - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(AW - 1);

  fft_state_e state, state_next;

  logic [63:0]   mem    [N];
  logic [31:0]   tw_rom [N/2];

  logic [AW-1:0] cnt;
  logic [AW-2:0] bf;
  logic [SW-1:0] stage;
  logic [1:0]    phase;

  logic [AW-1:0] load_addr, addr_a, addr_b, lo_mask, bf_ext, tw_full;
  logic [AW-2:0] tw_idx;
  logic [63:0]   a_q, b_q;
  logic [31:0]   w_q;
  logic          bypass_q;
  logic [31:0]   ya_re, ya_im, yb_re, yb_im;
  logic          rd_en, mul_en, add_en, wr_en;

  for (genvar k = 0; k < N / 2; k++) begin : g_tw
    localparam logic [31:0] TW = twiddle(N, k);
    assign tw_rom[k] = TW;
  end

  // Butterfly j of stage s pairs a = (j with a zero inserted at bit s) and a + 2^s.
  always_comb begin
    load_addr = AW'(bitrev(MAX_LOG2N'(cnt), AW));
    bf_ext    = {1'b0, bf};
    lo_mask   = (AW'(1) << stage) - AW'(1);
    addr_a    = ((bf_ext & ~lo_mask) << 1) | (bf_ext & lo_mask);
    addr_b    = addr_a | (AW'(1) << stage);
    tw_full   = (bf_ext & lo_mask) << (SW'(AW - 1) - stage);
    tw_idx    = (AW-1)'(tw_full);
    rd_en     = (state == COMPUTE) && (phase == 2'd0);
    mul_en    = (state == COMPUTE) && (phase == 2'd1);
    add_en    = (state == COMPUTE) && (phase == 2'd2);
    wr_en     = (state == COMPUTE) && (phase == 2'd3);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = LOAD;
      LOAD:    if (dready_i && cnt == LAST) state_next = COMPUTE;
      COMPUTE: if (wr_en && bf == BF_LAST && stage == ST_LAST) state_next = OUTPUT;
      OUTPUT:  if (!dl_busy_i && cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && dready_i) mem[load_addr] <= {x0_re_i, x0_im_i};
    if (wr_en) begin
      mem[addr_a] <= {ya_re, ya_im};
      mem[addr_b] <= {yb_re, yb_im};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      w_q      <= '0;
      bypass_q <= 1'b0;
    end else if (rd_en) begin
      a_q      <= mem[addr_a];
      b_q      <= mem[addr_b];
      w_q      <= tw_rom[tw_idx];
      bypass_q <= (tw_idx == '0);
    end
  end

  fft_butterfly u_bfly (
    .clk    (clk),
    .rst    (rst),
    .mul_en (mul_en),
    .add_en (add_en),
    .bypass (bypass_q),
    .a_re   (a_q[63:32]),
    .a_im   (a_q[31:0]),
    .b_re   (b_q[63:32]),
    .b_im   (b_q[31:0]),
    .w_re   (w_q[31:16]),
    .w_im   (w_q[15:0]),
    .ya_re  (ya_re),
    .ya_im  (ya_im),
    .yb_re  (yb_re),
    .yb_im  (yb_im)
  );

  // cnt serves as load count and output index; it wraps to 0 between the two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      bf          <= '0;
      stage       <= '0;
      phase       <= '0;
      busy_o      <= 1'b0;
      fft_ready_o <= 1'b0;
      fft_done_o  <= 1'b0;
      x0_re_o     <= '0;
      x0_im_o     <= '0;
    end else begin
      busy_o     <= (state != IDLE);
      fft_done_o <= 1'b0;
      case (state)
        IDLE: begin
          fft_ready_o <= 1'b0;
          cnt         <= '0;
          bf          <= '0;
          stage       <= '0;
          phase       <= '0;
        end
        LOAD: if (dready_i) cnt <= cnt + AW'(1);
        COMPUTE: begin
          phase <= phase + 2'd1;
          if (wr_en) begin
            if (bf == BF_LAST) begin
              bf    <= '0;
              stage <= stage + SW'(1);
            end else begin
              bf <= bf + (AW-1)'(1);
            end
          end
        end
        OUTPUT: begin
          if (!dl_busy_i) begin
            x0_re_o     <= mem[cnt][63:32];
            x0_im_o     <= mem[cnt][31:0];
            fft_ready_o <= 1'b1;
            fft_done_o  <= (cnt == LAST);
            cnt         <= cnt + AW'(1);
          end else begin
            fft_ready_o <= 1'b0;
          end
        end
        default: fft_ready_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_1024_point.sv
// Randomised bench for fft_1024_point (N=256) against an array-based FFT model.
module tb_fft_1024_point;

  localparam int unsigned N = 256;
  localparam int unsigned L = 8;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x0_re_i, x0_im_i;
  logic        start_i, dready_i, dl_busy_i;
  logic        fft_ready_o, fft_done_o, busy_o;
  logic [31:0] x0_re_o, x0_im_o;

  always #5 clk = ~clk;

  fft_1024_point #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .x0_re_i    (x0_re_i),
    .x0_im_i    (x0_im_i),
    .start_i    (start_i),
    .dready_i   (dready_i),
    .dl_busy_i  (dl_busy_i),
    .fft_ready_o(fft_ready_o),
    .fft_done_o (fft_done_o),
    .busy_o     (busy_o),
    .x0_re_o    (x0_re_o),
    .x0_im_o    (x0_im_o)
  );

  int     total = 0;
  int     bad = 0;
  longint xr[N], xi[N];
  longint mr[N], mi[N];
  longint exp_re[$], exp_im[$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint req,
                            input longint tol);
    total++;
    if (act > req + tol || act < req - tol) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d+-%0d", name, act, req, tol);
    end
  endtask

  function automatic longint wrap32(input longint v);
    logic [31:0] t;
    t = v[31:0];
    return longint'($signed(t));
  endfunction

  function automatic longint quant(input real v);
    longint r;
    r = longint'(v * 32768.0);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Reference DIT FFT on plain arrays: bit-reversed load, then log2N stages.
  task automatic run_model();
    int unsigned rev, h, k;
    longint ar, ai, br, bi, tr, ti, wr, wi, sr, si, dr, di;
    for (int n = 0; n < N; n++) begin
      rev = 0;
      for (int b = 0; b < L; b++) if (((n >> b) & 1) == 1) rev |= 1 << (L - 1 - b);
      mr[rev] = xr[n];
      mi[rev] = xi[n];
    end
    for (int s = 0; s < L; s++) begin
      h = 1 << s;
      for (int a = 0; a < N; a++) begin
        if ((a & h) == 0) begin
          k  = (a % h) * (N / (2 * h));
          ar = mr[a];     ai = mi[a];
          br = mr[a + h]; bi = mi[a + h];
          if (k == 0) begin
            tr = br; ti = bi;
          end else begin
            wr = quant($cos(2.0 * PI * k / N));
            wi = quant(-$sin(2.0 * PI * k / N));
            tr = wrap32((br * wr - bi * wi + 16384) >>> 15);
            ti = wrap32((br * wi + bi * wr + 16384) >>> 15);
          end
          sr = ar + tr; si = ai + ti; dr = ar - tr; di = ai - ti;
`ifdef FFT_STAGE_SCALE_EN
          sr = (sr + 1) >>> 1; si = (si + 1) >>> 1;
          dr = (dr + 1) >>> 1; di = (di + 1) >>> 1;
`endif
          mr[a] = wrap32(sr);     mi[a] = wrap32(si);
          mr[a + h] = wrap32(dr); mi[a + h] = wrap32(di);
        end
      end
    end
  endtask

  // Single compare process: every output beat is checked against the queue.
  initial begin : compare
    int  beat;
    bit  stalled;
    beat = 0;
    forever begin
      @(posedge clk);
      stalled = dl_busy_i;
      @(negedge clk);
      if (rst) begin
        beat = 0;
      end else begin
        if (stalled) check("stall_no_beat", fft_ready_o, 0);
        if (fft_ready_o) begin
          check("beat_expected", exp_re.size() > 0, 1);
          if (exp_re.size() > 0) begin
            check("x_re", longint'($signed(x0_re_o)), exp_re.pop_front());
            check("x_im", longint'($signed(x0_im_o)), exp_im.pop_front());
            check("done_flag", fft_done_o, beat == N - 1);
            beat = (beat == N - 1) ? 0 : beat + 1;
          end
        end else begin
          check("done_without_ready", fft_done_o, 0);
        end
      end
    end
  end

  task automatic run_frame(input bit gap, input bit stall, input bit chained,
                           input bit hold, input bit abort);
    int c;
    if (!chained) begin
      start_i = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      check("b2b_busy_low", busy_o, 0);
    end
    check("queue_drained", exp_re.size(), 0);
    if (!hold) start_i = 1'b0;
    run_model();
    for (int i = 0; i < N; i++) begin
      exp_re.push_back(mr[i]);
      exp_im.push_back(mi[i]);
    end
    for (int n = 0; n < N; n++) begin
      if (gap && (n % 2 == 1)) begin
        dready_i = 1'b0;
        x0_re_i  = $urandom;
        x0_im_i  = $urandom;
        @(posedge clk); #1;
      end
      dready_i = 1'b1;
      x0_re_i  = xr[n][31:0];
      x0_im_i  = xi[n][31:0];
      @(posedge clk); #1;
      if (n == 0) check("busy_rise", busy_o, 1);
    end
    dready_i = 1'b0;
    x0_re_i  = $urandom;
    if (abort) begin
      repeat (300) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("abort_ready", fft_ready_o, 0);
      check("abort_done", fft_done_o, 0);
      check("abort_busy", busy_o, 0);
      check("abort_re", x0_re_o, 0);
      check("abort_im", x0_im_o, 0);
      exp_re.delete();
      exp_im.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!fft_ready_o && c < 3 * N * L);
    check("compute_latency", c, 2 * N * L + 1);
    if (stall) begin
      repeat (5) @(posedge clk);
      #1 dl_busy_i = 1'b1;
      repeat (10) @(posedge clk);
      #1 dl_busy_i = 1'b0;
    end
    c = 0;
    while (!fft_done_o && c < 2 * N) begin
      @(posedge clk); #1;
      c++;
    end
    check("done_seen", fft_done_o, 1);
    check("busy_at_done", busy_o, 1);
    if (!hold) begin
      @(posedge clk); #1;
      check("ready_after_done", fft_ready_o, 0);
      check("busy_after_done", busy_o, 0);
      check("queue_after_done", exp_re.size(), 0);
    end
  endtask

  task automatic fill_random(input int unsigned range);
    for (int n = 0; n < N; n++) begin
      if (range == 0) begin
        xr[n] = longint'($signed(32'($urandom)));
        xi[n] = longint'($signed(32'($urandom)));
      end else begin
        xr[n] = longint'($urandom_range(2 * range, 0)) - range;
        xi[n] = longint'($urandom_range(2 * range, 0)) - range;
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; start_i = 1'b0; dready_i = 1'b0; dl_busy_i = 1'b0;
    x0_re_i = '0; x0_im_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", fft_ready_o, 0);
    check("reset_done", fft_done_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_re", x0_re_o, 0);
    check("reset_im", x0_im_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Impulse: flat spectrum of 1000
    for (int n = 0; n < N; n++) begin xr[n] = 0; xi[n] = 0; end
    xr[0] = 1000;
    run_model();
    for (int i = 0; i < N; i++) begin
      check_near("pin_impulse_re", mr[i], 1000, 8);
      check_near("pin_impulse_im", mi[i], 0, 8);
    end
    run_frame(0, 0, 0, 0, 0);

    // DC: all energy in bin 0, exactly N
    for (int n = 0; n < N; n++) begin xr[n] = 1; xi[n] = 0; end
    run_model();
    check("pin_dc_bin0_re", mr[0], N);
    check("pin_dc_bin0_im", mi[0], 0);
    check_near("pin_dc_bin5_re", mr[5], 0, 8);
    run_frame(0, 0, 0, 0, 0);

    // Alternating +-1000: all energy in bin N/2
    for (int n = 0; n < N; n++) begin xr[n] = (n % 2 == 0) ? 1000 : -1000; xi[n] = 0; end
    run_model();
`ifdef FFT_STAGE_SCALE_EN
    check_near("pin_alt_bin_half", mr[N/2], 1000, 2);
`else
    check_near("pin_alt_bin_half", mr[N/2], 1000 * N, 256);
`endif
    check_near("pin_alt_bin3", mr[3], 0, 256);
    run_frame(0, 0, 0, 0, 0);

    // Random bounded data, then the same data gapped with back-pressure
    fill_random(1 << 20);
    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 1, 0, 0, 0);

    // Full-range data exercises wrap-around
    fill_random(0);
    run_frame(0, 1, 0, 0, 0);

    // Reset mid-COMPUTE, then a fresh frame
    fill_random(1 << 16);
    run_frame(0, 0, 0, 0, 1);
    fill_random(1 << 18);
    run_frame(1, 0, 0, 0, 0);

    // Back-to-back frames with start_i held high
    fill_random(1 << 12);
    run_frame(0, 0, 0, 1, 0);
    fill_random(1 << 14);
    run_frame(0, 0, 1, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
